// File: rtl/fp_align_sequencer_if.sv
// Operand/result handshake bundle for the FP exponent-alignment sequencer.
interface fp_align_sequencer_if #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 24
);
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [EXP_W-1:0]   exp_a;
    logic [EXP_W-1:0]   exp_b;
    logic [MAN_W-1:0]   man_a;
    logic [MAN_W-1:0]   man_b;
    logic               out_valid;
    logic               out_ready;
    logic [EXP_W-1:0]   exp_out;
    logic [MAN_W-1:0]   man_big;
    logic [MAN_W+1:0]   man_small;
    logic               sticky;
    logic               swapped;
    logic               busy;

    modport master (
        output flush, in_valid, exp_a, exp_b, man_a, man_b, out_ready,
        input  in_ready, out_valid, exp_out, man_big, man_small, sticky, swapped, busy
    );

    modport slave (
        input  flush, in_valid, exp_a, exp_b, man_a, man_b, out_ready,
        output in_ready, out_valid, exp_out, man_big, man_small, sticky, swapped, busy
    );
endinterface

// File: rtl/fp_align_sequencer.sv
// Multi-cycle exponent alignment: picks the larger exponent, then shifts the
// smaller mantissa right one bit per cycle while collecting guard/round/sticky.
module fp_align_sequencer #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    fp_align_sequencer_if.slave bus
);
    localparam int unsigned SH_W  = MAN_W + 2;
    localparam int unsigned CNT_W = $clog2(SH_W + 1);

    typedef enum logic [1:0] {S_IDLE, S_DIFF, S_SHIFT, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [EXP_W-1:0]   r_exp_a;
    logic [EXP_W-1:0]   r_exp_b;
    logic [MAN_W-1:0]   r_man_a;
    logic [MAN_W-1:0]   r_man_b;
    logic [CNT_W-1:0]   r_cnt;
    logic [EXP_W-1:0]   r_exp_out;
    logic [MAN_W-1:0]   r_man_big;
    logic [SH_W-1:0]    r_man_small;
    logic               r_sticky;
    logic               r_swapped;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;

    logic [EXP_W:0]     w_diff;
    logic               w_carry;
    logic [EXP_W-1:0]   w_d;
    logic [31:0]        w_d32;
    logic [CNT_W-1:0]   w_k;
    logic               w_accept;

    // Subtract via complement + carry-in; carry-out set means exp_a >= exp_b.
    assign w_diff   = {1'b0, r_exp_a} + {1'b0, ~r_exp_b} + (EXP_W+1)'(1);
    assign w_carry  = w_diff[EXP_W];
    assign w_d      = w_carry ? w_diff[EXP_W-1:0] : (~w_diff[EXP_W-1:0] + EXP_W'(1));
    assign w_d32    = 32'(w_d);
    assign w_k      = (w_d32 > 32'(SH_W)) ? CNT_W'(SH_W) : CNT_W'(w_d32);
    assign w_accept = (r_state == S_IDLE) && bus.in_valid && r_in_ready && !bus.flush;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_DIFF;
            S_DIFF:  w_state_nxt = (w_k != '0) ? S_SHIFT : S_DONE;
            S_SHIFT: if (r_cnt == CNT_W'(1)) w_state_nxt = S_DONE;
            S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (bus.flush) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_out_valid <= (w_state_nxt == S_DONE);
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    // Operand capture, swap decision and the serial shifter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exp_a     <= '0;
            r_exp_b     <= '0;
            r_man_a     <= '0;
            r_man_b     <= '0;
            r_cnt       <= '0;
            r_exp_out   <= '0;
            r_man_big   <= '0;
            r_man_small <= '0;
            r_sticky    <= 1'b0;
            r_swapped   <= 1'b0;
        end else if (!bus.flush) begin
            if (w_accept) begin
                r_exp_a <= bus.exp_a;
                r_exp_b <= bus.exp_b;
                r_man_a <= bus.man_a;
                r_man_b <= bus.man_b;
            end
            if (r_state == S_DIFF) begin
                r_swapped   <= !w_carry;
                r_exp_out   <= w_carry ? r_exp_a : r_exp_b;
                r_man_big   <= w_carry ? r_man_a : r_man_b;
                r_man_small <= w_carry ? {r_man_b, 2'b00} : {r_man_a, 2'b00};
                r_sticky    <= 1'b0;
                r_cnt       <= w_k;
            end
            if (r_state == S_SHIFT) begin
                r_sticky    <= r_sticky | r_man_small[0];
                r_man_small <= r_man_small >> 1;
                r_cnt       <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.exp_out   = r_exp_out;
    assign bus.man_big   = r_man_big;
    assign bus.man_small = r_man_small;
    assign bus.sticky    = r_sticky;
    assign bus.swapped   = r_swapped;
endmodule

// File: tb/tb_fp_align_sequencer.sv
// Scoreboard bench: directed operand pairs with hand-computed alignments.
module tb_fp_align_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   last_acc = 0;
    logic prev_v = 1'b0;

    typedef struct {
        logic [7:0]  e;
        logic [23:0] big;
        logic [25:0] sm;
        logic        st;
        logic        sw;
        int          lat;
    } exp_t;

    exp_t q[$];

    fp_align_sequencer_if #(.EXP_W(8), .MAN_W(24)) bus ();

    fp_align_sequencer #(.EXP_W(8), .MAN_W(24)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Checks each result the first cycle it is presented.
    always @(negedge clk) begin
        if (bus.out_valid && !prev_v) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got out_valid=1 expected no result (t=%0t)", $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("exp_out",   32'(bus.exp_out),   32'(e.e));
                chk("man_big",   32'(bus.man_big),   32'(e.big));
                chk("man_small", 32'(bus.man_small), 32'(e.sm));
                chk("sticky",    32'(bus.sticky),    32'(e.st));
                chk("swapped",   32'(bus.swapped),   32'(e.sw));
                chk("latency",   32'(cyc - last_acc), 32'(e.lat));
            end
        end
        prev_v = bus.out_valid;
    end

    task automatic issue(input logic [7:0] ea, input logic [7:0] eb,
                         input logic [23:0] ma, input logic [23:0] mb);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            total++;
            bad++;
            $display("FAIL issue_timeout: got in_ready=0 expected 1");
        end
        bus.in_valid = 1'b1;
        bus.exp_a = ea;
        bus.exp_b = eb;
        bus.man_a = ma;
        bus.man_b = mb;
        @(posedge clk);
        #1;
        last_acc = cyc;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(negedge clk);
        while ((q.size() != 0 || bus.busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (q.size() != 0 || bus.busy) begin
            bad++;
            $display("FAIL wait_done: got pending=%0d busy=%0b expected 0/0", q.size(), bus.busy);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_in_ready"},  32'(bus.in_ready),  32'(0));
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'(0));
        chk({tag, "_busy"},      32'(bus.busy),      32'(0));
        chk({tag, "_exp_out"},   32'(bus.exp_out),   32'(0));
        chk({tag, "_man_big"},   32'(bus.man_big),   32'(0));
        chk({tag, "_man_small"}, 32'(bus.man_small), 32'(0));
        chk({tag, "_sticky"},    32'(bus.sticky),    32'(0));
        chk({tag, "_swapped"},   32'(bus.swapped),   32'(0));
    endtask

    initial begin
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.exp_a = '0;
        bus.exp_b = '0;
        bus.man_a = '0;
        bus.man_b = '0;

        #12;
        chk_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_release_in_ready", 32'(bus.in_ready), 32'(1));

        // 1: equal exponents, no shift
        q.push_back('{e:8'd127, big:24'h800000, sm:26'h3000000, st:1'b0, sw:1'b0, lat:1});
        issue(8'd127, 8'd127, 24'h800000, 24'hC00000);
        wait_done();

        // 2: k=3, a larger
        q.push_back('{e:8'd130, big:24'h900000, sm:26'h0600000, st:1'b1, sw:1'b0, lat:4});
        issue(8'd130, 8'd127, 24'h900000, 24'hC00001);
        wait_done();

        // 3: b larger by one
        q.push_back('{e:8'd101, big:24'hA00000, sm:26'h1000002, st:1'b0, sw:1'b1, lat:2});
        issue(8'd100, 8'd101, 24'h800001, 24'hA00000);
        wait_done();

        // 4: shift capped at 26
        q.push_back('{e:8'd200, big:24'hFFFFFF, sm:26'h0, st:1'b1, sw:1'b0, lat:27});
        issue(8'd200, 8'd1, 24'hFFFFFF, 24'h800000);
        wait_done();

        // 5: consumer stalls in DONE
        bus.out_ready = 1'b0;
        q.push_back('{e:8'd130, big:24'h900000, sm:26'h0600000, st:1'b1, sw:1'b0, lat:4});
        issue(8'd130, 8'd127, 24'h900000, 24'hC00001);
        begin
            int n;
            n = 0;
            while (!bus.out_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_out_valid", 32'(bus.out_valid), 32'(1));
            chk("hold_in_ready",  32'(bus.in_ready),  32'(0));
            chk("hold_man_small", 32'(bus.man_small), 32'h0600000);
            chk("hold_exp_out",   32'(bus.exp_out),   32'd130);
            chk("hold_sticky",    32'(bus.sticky),    32'(1));
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("handoff_in_ready",  32'(bus.in_ready),  32'(1));
        chk("handoff_out_valid", 32'(bus.out_valid), 32'(0));
        wait_done();

        // 6a: flush during SHIFT drops the operation
        issue(8'd200, 8'd1, 24'hFFFFFF, 24'h800000);
        repeat (5) @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        chk("flush_busy",      32'(bus.busy),      32'(0));
        chk("flush_out_valid", 32'(bus.out_valid), 32'(0));
        repeat (30) @(negedge clk);

        // 6b: async reset during SHIFT
        issue(8'd200, 8'd1, 24'hFFFFFF, 24'h800000);
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_in_ready", 32'(bus.in_ready), 32'(1));

        q.push_back('{e:8'd101, big:24'hA00000, sm:26'h1000002, st:1'b0, sw:1'b1, lat:2});
        issue(8'd100, 8'd101, 24'h800001, 24'hA00000);
        wait_done();
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
